sbox_pipe: RTL
==============

// Module: sbox_pipe
// PURPOSE
//  Multi-lane, pipelined AES byte-substitution unit with valid/ready handshake.
//  Applies the AES S-box to LANES bytes per beat: LANES=4 serves key-expansion SubWord, LANES=16 full-state SubBytes.
//  Per-beat forward/inverse selection when the inverse option is compiled in.
//  Sits between the round-key/state registers and ShiftRows/MixColumns in the round datapath.
// PARAMETERS
//  LANES   4  bytes substituted per beat (1..16); data width = 8*LANES
//  STAGES  2  register stages input->output (1..3); stage 1 registers the lookup, later stages are pure retiming
//  TAG_W   4  sideband tag width carried alongside each beat (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        unit can accept a beat this cycle
//  in_data    in   8*LANES  bytes to substitute; lane i = in_data[8*i+7:8*i]
//  in_inv     in   1        1 = inverse S-box for this beat (ignored unless SBOX_INV_EN)
//  in_tag     in   TAG_W    opaque sideband, returned unchanged with the result
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts the beat
//  out_data   out  8*LANES  substituted bytes, same lane ordering
//  out_tag    out  TAG_W    tag of the beat on out_data
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; out_valid=0, out_data=0, out_tag=0. in_ready=1 in the first cycle after reset release.
//  - Transfer happens on any edge where valid&&ready on that interface.
//  - Elastic pipeline: stage k loads when it is empty or its content moves on this cycle. in_ready = !v[0] || adv[0]; adv[last] = out_ready.
//  - Latency STAGES cycles from input transfer to out_valid with no back-pressure. Throughput 1 beat/cycle, including when the pipe is full and out_ready=1.
//  - Lookup is combinational on in_data in front of stage 1. No lookup logic follows a register.
//  - The per-beat inv bit and the tag travel in each stage with the data.
//  - Back-pressure: while out_valid && !out_ready, out_data/out_tag hold stable. Once all stages are full, in_ready=0. No beat is dropped, duplicated or reordered.
//  - Upstream protocol: once in_valid is asserted, it holds with stable data until it is accepted. The block does not check this.
//  - Simultaneous accept at input and output while full is legal; occupancy is unchanged.
//  - Reset asserted mid-stream discards all in-flight beats. Outputs return to reset values on the next edge.
//  - Data registers of empty stages keep their last value. Only out_data is zeroed, and only by reset.
// CONFIGURATION
//  SBOX_INV_EN defined:
//    - Each lane instance also holds the inverse table, and in_inv selects per beat: 0 forward, 1 inverse.
//    - Lanes of one beat always share the same mode.
//  SBOX_INV_EN undefined:
//    - Forward table only; in_inv is ignored, and the inverse table and the inv pipeline bits are not built.
//    - Port list is identical in both builds.
// STRUCTURE
//  - Shared package aes_pkg: constants AES_SBOX and AES_INV_SBOX as 256x8 arrays, and functions sbox_fwd(byte) and sbox_inv(byte).
//  - Sub-module sbox_byte: combinational single-byte lookup with inputs b and inv, output s; instantiated LANES times via generate.
//  - sbox_pipe itself holds only the valid/ready stage control and the data/tag/inv registers.
// TESTING
//  - Forward, LANES=4, STAGES=2:
//      - 32'h00102030 -> 32'h63cab704 two cycles after accept, with its tag echoed.
//      - Single bytes 8'h53 -> 8'hed and 8'hff -> 8'h16.
//  - Inverse (SBOX_INV_EN): 32'h63cab704 with in_inv=1 -> 32'h00102030; byte 8'h16 -> 8'hff.
//  - Streaming: 8 back-to-back beats with out_ready=1 -> 8 results on 8 consecutive cycles, tags in order 0..7.
//  - Back-pressure: out_ready=0 for 3 cycles mid-stream ->
//      - in_ready drops once STAGES beats are held, out_data stays stable.
//      - All beats delivered in order after release.
//  - Reset mid-stream: rst high 1 cycle with 2 beats in flight -> out_valid=0, out_data=0 next cycle, and neither beat appears afterwards.
//  - Sweep all 256 byte values in every lane:
//      - Results match aes_pkg.
//      - With SBOX_INV_EN, forward-then-inverse returns the input.
//      - Repeat for LANES=1,16 and STAGES=1,3.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES forward/inverse S-box tables and single-byte lookup functions
package aes_pkg;

  localparam logic [7:0] AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] AES_INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return AES_INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// rtl/sbox_byte.sv - combinational single-byte S-box; inverse table only when SBOX_INV_EN is defined
module sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] b,
  input  logic       inv,
  output logic [7:0] s
);

`ifdef SBOX_INV_EN
  assign s = inv ? sbox_inv(b) : sbox_fwd(b);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign s = sbox_fwd(b);
`endif

endmodule

// File: rtl/sbox_pipe.sv
// rtl/sbox_pipe.sv - elastic LANES-wide AES S-box pipeline of STAGES registers; SBOX_INV_EN adds per-beat inverse
module sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 8 * LANES;

  logic [W-1:0]      sub_data;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] take;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_byte u_sbox (
      .b   (in_data[8*i +: 8]),
      .inv (in_inv),
      .s   (sub_data[8*i +: 8])
    );
  end

  // Stage k may load when it, or any stage after it, has a hole, or the sink drains.
  always_comb begin
    logic hole;
    hole = out_ready;
    take = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole    = hole || !v_q[k];
      take[k] = hole;
    end
  end

  assign in_ready = take[0];

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (take[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = sub_data;
        tag_d[0]  = in_tag;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (take[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end
  end

  // Only the output stage is cleared; inner data registers are don't-care while empty.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    if (rst) begin
      v_q              <= '0;
      data_q[STAGES-1] <= '0;
      tag_q[STAGES-1]  <= '0;
    end else begin
      v_q <= v_d;
    end
  end

`ifdef SBOX_INV_EN
  logic [STAGES-1:0] inv_q, inv_d;
  logic              unused_inv_q;

  always_comb begin
    inv_d = inv_q;
    if (take[0] && in_valid) inv_d[0] = in_inv;
    for (int k = 1; k < STAGES; k++) begin
      if (take[k] && v_q[k-1]) inv_d[k] = inv_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    inv_q <= inv_d;
  end

  // The mode already took effect at the lookup; the bits only track each beat's mode.
  assign unused_inv_q = ^inv_q;
`endif

  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule
